// File: rtl/bus_responder.sv
// bus_responder: target side of the CPU memory bus.
// Answers every CPU read/write cycle with RAM, a reset-vector responder,
// an output byte FIFO drained by an external consumer, and an optional
// free-running 16-bit timer with a coherent high-byte shadow.
//
// Build option: define BUS_RESPONDER_TIMER_EN to include the timer/shadow.
// Without it, 0xD002/0xD003 read as 0x00 and writes to them are ignored.
//
// Memory map (reads are combinational, writes commit on the rising edge):
//   0x0000..2**RAM_AW-1 : RAM (read/write)
//   0xD000              : read FIFO head, write pushes a byte
//   0xD001              : read {overflow,3'b000,count}, write bit7=1 clears overflow
//   0xD002              : timer[7:0]; a read also latches timer[15:8] into shadow
//   0xD003              : shadow (timer[15:8] captured by the last 0xD002 read)
//   0xFFFC / 0xFFFD     : RESET_VECTOR low / high byte
//   anything else       : 0xFF
module bus_responder #(
  parameter int          RAM_AW       = 15,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] RESET_VECTOR = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        read_write,
  input  logic [7:0]  data_write,
  output logic [7:0]  data_read,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam int          RAM_WORDS = 2 ** RAM_AW;
  localparam logic [3:0]  DEPTH_C  = 4'(FIFO_DEPTH);

  localparam logic [15:0] ADDR_FIFO = 16'hD000;
  localparam logic [15:0] ADDR_STAT = 16'hD001;
  localparam logic [15:0] ADDR_TLO  = 16'hD002;
  localparam logic [15:0] ADDR_THI  = 16'hD003;
  localparam logic [15:0] ADDR_VLO  = 16'hFFFC;
  localparam logic [15:0] ADDR_VHI  = 16'hFFFD;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic ram_sel;
  logic wr_en;
  logic push;
  logic pop;
  logic full;
  logic push_ok;
  logic ovf_set;
  logic ovf_clr;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q,  count_d;
  logic          overflow_q, overflow_d;

  assign ram_sel = (address[15:RAM_AW] == '0);
  assign wr_en   = ~read_write;
  assign push    = wr_en && (address == ADDR_FIFO);
  assign pop     = out_valid && out_ready;
  assign full    = (count_q == DEPTH_C);
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_clr = wr_en && (address == ADDR_STAT) && data_write[7];

  // ---------------------------------------------------------------------------
  // RAM: uninitialised storage, asynchronous read so the CPU sees zero latency.
  // Writes are gated by rst so a reset in progress blocks the pending write.
  // ---------------------------------------------------------------------------
  logic [7:0] ram_mem [RAM_WORDS];

  // Commit CPU writes into the RAM region.
  always_ff @(posedge clk) begin
    if (rst && wr_en && ram_sel) begin
      ram_mem[address[RAM_AW-1:0]] <= data_write;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: one byte register per slot, loaded when the write pointer
  // points at it. Data registers carry no reset; count/pointers define validity.
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_mem [FIFO_DEPTH];

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_slot
    logic [7:0] entry_q;

    // Load this slot when an accepted push targets it.
    always_ff @(posedge clk) begin
      if (rst && push_ok && (wr_ptr_q == PW'(gi))) begin
        entry_q <= data_write;
      end
    end

    assign fifo_mem[gi] = entry_q;
  end

  // FIFO pointer, occupancy and sticky-overflow next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {3'b000, push_ok} - {3'b000, pop};

    // A dropped push on the same edge as a clear leaves overflow set.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (count_q != 4'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Optional timer with shadowed high byte
  // ---------------------------------------------------------------------------
  logic [7:0] timer_lo_rd;
  logic [7:0] timer_hi_rd;

`ifdef BUS_RESPONDER_TIMER_EN
  logic [15:0] timer_q,  timer_d;
  logic [7:0]  shadow_q, shadow_d;

  // Free-running count; a read of the low byte snapshots the high byte.
  always_comb begin
    timer_d  = timer_q + 16'd1;
    shadow_d = shadow_q;
    if (read_write && (address == ADDR_TLO)) begin
      shadow_d = timer_q[15:8];
    end
  end

  // Timer and shadow registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q  <= '0;
      shadow_q <= '0;
    end else begin
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
    end
  end

  assign timer_lo_rd = timer_q[7:0];
  assign timer_hi_rd = shadow_q;
`else
  assign timer_lo_rd = 8'h00;
  assign timer_hi_rd = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Read map: purely combinational from address and current state, so a write
  // cycle never changes data_read before its edge.
  // ---------------------------------------------------------------------------
  // Select the byte returned to the CPU.
  always_comb begin
    data_read = 8'hFF;
    if (ram_sel) begin
      data_read = ram_mem[address[RAM_AW-1:0]];
    end else begin
      case (address)
        ADDR_FIFO: data_read = out_data;
        ADDR_STAT: data_read = {overflow_q, 3'b000, count_q};
        ADDR_TLO:  data_read = timer_lo_rd;
        ADDR_THI:  data_read = timer_hi_rd;
        ADDR_VLO:  data_read = RESET_VECTOR[7:0];
        ADDR_VHI:  data_read = RESET_VECTOR[15:8];
        default:   data_read = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed and random stimulus against a queue-based
// reference model of the bus_responder memory map.
// Timer checks follow BUS_RESPONDER_TIMER_EN, as the design does.
module tb_bus_responder;

  logic        clk;
  logic        rst;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_write;
  logic [7:0]  data_read;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .read_write (read_write),
    .data_write (data_write),
    .data_read  (data_read),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  fifo_m [$];
  logic        ovf_m;
  logic [15:0] timer_m;
  logic [7:0]  shadow_m;
  logic [7:0]  ram_m [int];
  logic [7:0]  rd_obs;

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a < 16'h8000) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 8'h00;
    case (a)
      16'hD000: return (fifo_m.size() != 0) ? fifo_m[0] : 8'h00;
      16'hD001: return {ovf_m, 3'b000, 4'(fifo_m.size())};
`ifdef BUS_RESPONDER_TIMER_EN
      16'hD002: return timer_m[7:0];
      16'hD003: return shadow_m;
`else
      16'hD002: return 8'h00;
      16'hD003: return 8'h00;
`endif
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'h02;
      default:  return 8'hFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at posedge+1, check before the edge, advance model at the edge.
  task automatic cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic rdy);
    logic pop_m, push_m, set_m;
    address    = a;
    read_write = rw;
    data_write = wd;
    out_ready  = rdy;
    #1;
    rd_obs = data_read;
    check($sformatf("data_read@%04h", a), data_read, model_read(a));
    check("out_valid", {7'b0, out_valid}, {7'b0, fifo_m.size() != 0});
    check("out_data", out_data, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00);
    check("overflow", {7'b0, overflow}, {7'b0, ovf_m});
    $display("cyc a=%04h rw=%0d wd=%02h rdy=%0d rd=%02h cnt=%0d ovf=%0d",
             a, rw, wd, rdy, rd_obs, fifo_m.size(), ovf_m);
    pop_m  = (fifo_m.size() != 0) && rdy;
    push_m = !rw && (a == 16'hD000);
    set_m  = push_m && (fifo_m.size() == 8) && !pop_m;
    @(posedge clk);
    if (!set_m) begin
      if (pop_m)  void'(fifo_m.pop_front());
      if (push_m) fifo_m.push_back(wd);
    end
    if (set_m) ovf_m = 1'b1;
    else if (!rw && (a == 16'hD001) && wd[7]) ovf_m = 1'b0;
    if (!rw && (a < 16'h8000)) ram_m[int'(a)] = wd;
    if (rw && (a == 16'hD002)) shadow_m = timer_m[15:8];
    timer_m = timer_m + 16'd1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_m.delete();
    ovf_m    = 1'b0;
    timer_m  = '0;
    shadow_m = '0;
    address    = 16'h9000;
    read_write = 1'b1;
    data_write = 8'h00;
    out_ready  = 1'b0;
    #1;
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_overflow", {7'b0, overflow}, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    address = 16'h9000; read_write = 1'b1; data_write = 8'h00; out_ready = 1'b0;
    do_reset();

    // Reset-state reads
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("stat_after_reset", rd_obs, 8'h00);
    cycle(16'hFFFC, 1'b1, 8'h00, 1'b0); check("vector_lo", rd_obs, 8'h00);
    cycle(16'hFFFD, 1'b1, 8'h00, 1'b0); check("vector_hi", rd_obs, 8'h02);
    cycle(16'hFFFC, 1'b0, 8'h33, 1'b0);
    cycle(16'hFFFC, 1'b1, 8'h00, 1'b0); check("vector_lo_after_write", rd_obs, 8'h00);

    // RAM
    cycle(16'h0010, 1'b0, 8'h5A, 1'b0);
    cycle(16'h7FFF, 1'b0, 8'hA5, 1'b0);
    cycle(16'h0010, 1'b1, 8'h00, 1'b0); check("ram_0010", rd_obs, 8'h5A);
    cycle(16'h7FFF, 1'b1, 8'h00, 1'b0); check("ram_7fff", rd_obs, 8'hA5);
    cycle(16'h9000, 1'b1, 8'h00, 1'b0); check("unmapped_9000", rd_obs, 8'hFF);

    // FIFO ordering
    cycle(16'hD000, 1'b0, 8'h11, 1'b0);
    cycle(16'hD000, 1'b0, 8'h22, 1'b0);
    cycle(16'hD000, 1'b0, 8'h33, 1'b0);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("fifo_count3", rd_obs, 8'h03);
    cycle(16'hD000, 1'b1, 8'h00, 1'b1); check("pop_1", rd_obs, 8'h11);
    cycle(16'hD000, 1'b1, 8'h00, 1'b1); check("pop_2", rd_obs, 8'h22);
    cycle(16'hD000, 1'b1, 8'h00, 1'b1); check("pop_3", rd_obs, 8'h33);
    cycle(16'hD001, 1'b1, 8'h00, 1'b1); check("fifo_empty", rd_obs, 8'h00);

    // Overflow
    for (int i = 0; i < 9; i++) cycle(16'hD000, 1'b0, 8'(i), 1'b0);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("stat_overflow", rd_obs, 8'h88);
    cycle(16'hD001, 1'b0, 8'h80, 1'b0);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("stat_cleared", rd_obs, 8'h08);

    // Full push + pop on the same edge
    cycle(16'hD000, 1'b0, 8'hEE, 1'b1);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("stat_full_pushpop", rd_obs, 8'h08);
    for (int i = 0; i < 8; i++) cycle(16'hD000, 1'b1, 8'h00, 1'b1);
    check("last_entry_ee", rd_obs, 8'hEE);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("drained", rd_obs, 8'h00);

    // Timer coherence
    do_reset();
    repeat (16'h0134) cycle(16'h9000, 1'b1, 8'h00, 1'b0);
    cycle(16'hD002, 1'b1, 8'h00, 1'b0);
`ifdef BUS_RESPONDER_TIMER_EN
    check("timer_lo", rd_obs, 8'h34);
`else
    check("timer_lo", rd_obs, 8'h00);
`endif
    cycle(16'hD003, 1'b1, 8'h00, 1'b0);
`ifdef BUS_RESPONDER_TIMER_EN
    check("timer_shadow", rd_obs, 8'h01);
`else
    check("timer_shadow", rd_obs, 8'h00);
`endif

    // Reset in the middle of a push cycle aborts the push
    address = 16'hD000; read_write = 1'b0; data_write = 8'h77; out_ready = 1'b0;
    #2;
    do_reset();
    cycle(16'hD001, 1'b1, 8'h00, 1'b0); check("abort_push", rd_obs, 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      logic [15:0] a;
      logic rdy;
      op  = $urandom_range(0, 7);
      rdy = ($urandom_range(0, 3) == 0);
      case (op)
        0, 1: cycle(16'hD000, 1'b0, 8'($urandom), rdy);
        2:    cycle(16'hD000, 1'b1, 8'h00, rdy);
        3:    cycle(16'hD001, 1'b1, 8'h00, rdy);
        4:    cycle(16'hD001, 1'b0, 8'($urandom), rdy);
        5: begin
          a = 16'h0100 + 16'($urandom_range(0, 7));
          cycle(a, 1'b0, 8'($urandom), rdy);
        end
        6: begin
          a = 16'h0100 + 16'($urandom_range(0, 7));
          if (ram_m.exists(int'(a))) cycle(a, 1'b1, 8'h00, rdy);
          else cycle(a, 1'b0, 8'($urandom), rdy);
        end
        default: begin
          a = 16'hE000 + 16'($urandom_range(0, 16'h0FFF));
          cycle(a, ($urandom_range(0, 1) == 1), 8'($urandom), rdy);
        end
      endcase
    end
    cycle(16'hD002, 1'b1, 8'h00, 1'b0);
    cycle(16'hD003, 1'b1, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
